// File: rtl/frame_bank_file.sv
// Banked frame register file: whole-bank write, registered whole-bank read,
// and a background engine that copies one bank into another a frame per cycle.
module frame_bank_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAMES = 16,
    parameter int unsigned BANKS  = 2,
    localparam int unsigned BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [BW-1:0]            wr_bank,
    input  logic [FRAMES*DATA_W-1:0] wr_data,
    input  logic [BW-1:0]            rd_bank,
    output logic [FRAMES*DATA_W-1:0] rd_data,
    input  logic                     copy_req,
    input  logic [BW-1:0]            copy_src,
    input  logic [BW-1:0]            copy_dst,
    output logic                     busy,
    output logic                     copy_done,
    output logic                     wr_drop
);

    localparam int unsigned IW     = $clog2(FRAMES);
    localparam logic [BW:0] NBANKS = (BW+1)'(BANKS);
    localparam logic [IW-1:0] LAST = IW'(FRAMES - 1);

    typedef enum logic {IDLE, COPY} state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     src_q;
    logic [BW-1:0]     dst_q;
    logic [DATA_W-1:0] mem [BANKS][FRAMES];

    logic wr_ok;
    logic rd_ok;
    logic req_ok;

    always_comb begin
        // A write landing on the bank being filled by the copy engine is dropped whole.
        wr_ok  = wr_en && ({1'b0, wr_bank} < NBANKS) && !(busy && (wr_bank == dst_q));
        rd_ok  = ({1'b0, rd_bank} < NBANKS);
        req_ok = copy_req && ({1'b0, copy_src} < NBANKS) && ({1'b0, copy_dst} < NBANKS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                for (int unsigned f = 0; f < FRAMES; f++) begin
                    mem[b][f] <= '0;
                end
            end
            rd_data   <= '0;
            state     <= IDLE;
            idx       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            busy      <= 1'b0;
            copy_done <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            copy_done <= 1'b0;
            wr_drop   <= wr_en && !wr_ok;

            for (int unsigned f = 0; f < FRAMES; f++) begin
                rd_data[f*DATA_W +: DATA_W] <= rd_ok ? mem[rd_bank][f] : '0;
            end

            if (wr_ok) begin
                for (int unsigned f = 0; f < FRAMES; f++) begin
                    mem[wr_bank][f] <= wr_data[f*DATA_W +: DATA_W];
                end
            end

            case (state)
                IDLE: begin
                    if (req_ok) begin
                        src_q <= copy_src;
                        dst_q <= copy_dst;
                        idx   <= '0;
                        state <= COPY;
                        busy  <= 1'b1;
                    end
                end
                COPY: begin
                    // Source is read live, so writes to src ahead of idx are carried over.
                    mem[dst_q][idx] <= mem[src_q][idx];
                    if (idx == LAST) begin
                        idx       <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        copy_done <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_bank_file.sv
// Directed bench for frame_bank_file: a 2-bank default instance and a small
// 3-bank instance for out-of-range bank handling.
module tb_frame_bank_file;

    localparam int unsigned AW = 16 * 32;
    localparam int unsigned BWD = 4 * 8;

    logic clk;
    logic rst_n;

    logic          a_wr_en, a_wr_bank, a_rd_bank, a_copy_req, a_copy_src, a_copy_dst;
    logic [AW-1:0] a_wr_data, a_rd_data;
    logic          a_busy, a_copy_done, a_wr_drop;

    logic           b_wr_en, b_copy_req;
    logic [1:0]     b_wr_bank, b_rd_bank, b_copy_src, b_copy_dst;
    logic [BWD-1:0] b_wr_data, b_rd_data;
    logic           b_busy, b_copy_done, b_wr_drop;

    int vectors;
    int miscompares;

    frame_bank_file #(.DATA_W(32), .FRAMES(16), .BANKS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_data(a_wr_data),
        .rd_bank(a_rd_bank), .rd_data(a_rd_data),
        .copy_req(a_copy_req), .copy_src(a_copy_src), .copy_dst(a_copy_dst),
        .busy(a_busy), .copy_done(a_copy_done), .wr_drop(a_wr_drop)
    );

    frame_bank_file #(.DATA_W(8), .FRAMES(4), .BANKS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_data(b_wr_data),
        .rd_bank(b_rd_bank), .rd_data(b_rd_data),
        .copy_req(b_copy_req), .copy_src(b_copy_src), .copy_dst(b_copy_dst),
        .busy(b_busy), .copy_done(b_copy_done), .wr_drop(b_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] pat_a(input logic [31:0] base, input logic [31:0] step);
        logic [AW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = base + 32'(i) * step;
        return r;
    endfunction

    function automatic logic [BWD-1:0] pat_b(input logic [7:0] base, input logic [7:0] step);
        logic [BWD-1:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = base + 8'(i) * step;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if (a_rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h want 0", a_rd_data); end
        vectors++;
        if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        vectors++;
        if (a_copy_done !== 1'b0) begin miscompares++; $display("FAIL reset_copy_done: got %b want 0", a_copy_done); end
        vectors++;
        if (a_wr_drop !== 1'b0) begin miscompares++; $display("FAIL reset_wr_drop: got %b want 0", a_wr_drop); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bulk_write;
        logic [AW-1:0] exp;
        exp = pat_a(32'hA000_0000, 32'd1);
        a_wr_en = 1'b1; a_wr_bank = 1'b1; a_wr_data = exp; a_rd_bank = 1'b1;
        tick();
        a_wr_en = 1'b0;
        vectors++;
        if (a_rd_data !== '0) begin miscompares++; $display("FAIL bulk_rd_same_edge: got %h want 0", a_rd_data); end
        tick();
        vectors++;
        if (a_rd_data !== exp) begin miscompares++; $display("FAIL bulk_rd_bank1: got %h want %h", a_rd_data, exp); end
        a_rd_bank = 1'b0;
        tick();
        vectors++;
        if (a_rd_data !== '0) begin miscompares++; $display("FAIL bulk_rd_bank0: got %h want 0", a_rd_data); end
    endtask

    task automatic test_read_before_write;
        logic [AW-1:0] p11, p22;
        p11 = pat_a(32'h11, 32'd0);
        p22 = pat_a(32'h22, 32'd0);
        a_wr_en = 1'b1; a_wr_bank = 1'b0; a_wr_data = p11; a_rd_bank = 1'b0;
        tick();
        a_wr_en = 1'b0;
        tick();
        vectors++;
        if (a_rd_data !== p11) begin miscompares++; $display("FAIL rbw_setup: got %h want %h", a_rd_data, p11); end
        a_wr_en = 1'b1; a_wr_data = p22;
        tick();
        a_wr_en = 1'b0;
        vectors++;
        if (a_rd_data !== p11) begin miscompares++; $display("FAIL rbw_edge_k: got %h want %h", a_rd_data, p11); end
        tick();
        vectors++;
        if (a_rd_data !== p22) begin miscompares++; $display("FAIL rbw_edge_k1: got %h want %h", a_rd_data, p22); end
    endtask

    task automatic test_copy;
        logic [AW-1:0] p3;
        p3 = pat_a(32'd0, 32'd3);
        a_wr_en = 1'b1; a_wr_bank = 1'b0; a_wr_data = p3;
        tick();
        a_wr_en = 1'b0;
        a_copy_req = 1'b1; a_copy_src = 1'b0; a_copy_dst = 1'b1;
        tick();
        a_copy_req = 1'b0;
        vectors++;
        if (a_busy !== 1'b1) begin miscompares++; $display("FAIL copy_busy_accept: got %b want 1", a_busy); end
        for (int e = 1; e <= 16; e++) begin
            if (e == 5) begin
                a_copy_req = 1'b1; a_copy_src = 1'b1; a_copy_dst = 1'b0;
            end else begin
                a_copy_req = 1'b0;
            end
            tick();
            vectors++;
            if (a_busy !== (e < 16)) begin
                miscompares++; $display("FAIL copy_busy_e%0d: got %b want %b", e, a_busy, (e < 16));
            end
            vectors++;
            if (a_copy_done !== (e == 16)) begin
                miscompares++; $display("FAIL copy_done_e%0d: got %b want %b", e, a_copy_done, (e == 16));
            end
        end
        a_copy_req = 1'b0;
        a_rd_bank = 1'b1;
        tick();
        vectors++;
        if (a_copy_done !== 1'b0) begin miscompares++; $display("FAIL copy_done_width: got %b want 0", a_copy_done); end
        vectors++;
        if (a_busy !== 1'b0) begin miscompares++; $display("FAIL copy_no_requeue: got %b want 0", a_busy); end
        vectors++;
        if (a_rd_data !== p3) begin miscompares++; $display("FAIL copy_dst: got %h want %h", a_rd_data, p3); end
        a_rd_bank = 1'b0;
        tick();
        vectors++;
        if (a_rd_data !== p3) begin miscompares++; $display("FAIL copy_src_intact: got %h want %h", a_rd_data, p3); end
    endtask

    task automatic test_conflict;
        logic [AW-1:0] exp_dst, p5a;
        p5a = pat_a(32'h5A, 32'd0);
        for (int i = 0; i < 16; i++) exp_dst[i*32 +: 32] = (i < 8) ? 32'h100 + 32'(i) : 32'h5A;
        a_wr_en = 1'b1; a_wr_bank = 1'b0; a_wr_data = pat_a(32'h100, 32'd1);
        tick();
        a_wr_en = 1'b0;
        a_copy_req = 1'b1; a_copy_src = 1'b0; a_copy_dst = 1'b1;
        tick();
        a_copy_req = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            a_wr_en = (e == 3) || (e == 8);
            if (e == 3) begin a_wr_bank = 1'b1; a_wr_data = pat_a(32'hFFFF_FFFF, 32'd0); end
            if (e == 8) begin a_wr_bank = 1'b0; a_wr_data = p5a; end
            tick();
            a_wr_en = 1'b0;
            if (e == 3) begin
                vectors++;
                if (a_wr_drop !== 1'b1) begin miscompares++; $display("FAIL conflict_drop: got %b want 1", a_wr_drop); end
            end
            if (e == 4) begin
                vectors++;
                if (a_wr_drop !== 1'b0) begin miscompares++; $display("FAIL conflict_drop_width: got %b want 0", a_wr_drop); end
            end
            if (e == 8) begin
                vectors++;
                if (a_wr_drop !== 1'b0) begin miscompares++; $display("FAIL conflict_src_write: got %b want 0", a_wr_drop); end
            end
            if (e == 16) begin
                vectors++;
                if (a_copy_done !== 1'b1) begin miscompares++; $display("FAIL conflict_done: got %b want 1", a_copy_done); end
            end
        end
        a_rd_bank = 1'b1;
        tick();
        vectors++;
        if (a_rd_data !== exp_dst) begin miscompares++; $display("FAIL conflict_dst: got %h want %h", a_rd_data, exp_dst); end
        a_rd_bank = 1'b0;
        tick();
        vectors++;
        if (a_rd_data !== p5a) begin miscompares++; $display("FAIL conflict_src: got %h want %h", a_rd_data, p5a); end
    endtask

    task automatic test_reset_mid_copy;
        bit seen;
        a_copy_req = 1'b1; a_copy_src = 1'b0; a_copy_dst = 1'b1; a_rd_bank = 1'b1;
        tick();
        a_copy_req = 1'b0;
        repeat (7) tick();
        vectors++;
        if (a_busy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy: got %b want 1", a_busy); end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (a_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        vectors++;
        if (a_copy_done !== 1'b0) begin miscompares++; $display("FAIL rst_copy_done: got %b want 0", a_copy_done); end
        vectors++;
        if (a_rd_data !== '0) begin miscompares++; $display("FAIL rst_rd_data: got %h want 0", a_rd_data); end
        a_copy_req = 1'b1; a_copy_src = 1'b1; a_copy_dst = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        a_copy_req = 1'b0;
        vectors++;
        if (a_busy !== 1'b1) begin miscompares++; $display("FAIL rst_new_accept: got %b want 1", a_busy); end
        vectors++;
        if (a_rd_data !== '0) begin miscompares++; $display("FAIL rst_bank1_cleared: got %h want 0", a_rd_data); end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (a_copy_done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rst_copy_completes: got no copy_done want pulse within 20 cycles"); end
        a_rd_bank = 1'b0;
        tick();
        vectors++;
        if (a_rd_data !== '0) begin miscompares++; $display("FAIL rst_bank0_cleared: got %h want 0", a_rd_data); end
    endtask

    task automatic test_out_of_range;
        logic [BWD-1:0] p30;
        p30 = pat_b(8'h30, 8'd1);
        b_wr_en = 1'b1; b_wr_bank = 2'd2; b_wr_data = p30;
        tick();
        b_wr_en = 1'b0;
        vectors++;
        if (b_wr_drop !== 1'b0) begin miscompares++; $display("FAIL oor_valid_write: got %b want 0", b_wr_drop); end
        b_wr_en = 1'b1; b_wr_bank = 2'd3; b_wr_data = pat_b(8'hEE, 8'd0);
        tick();
        b_wr_en = 1'b0;
        vectors++;
        if (b_wr_drop !== 1'b1) begin miscompares++; $display("FAIL oor_write_drop: got %b want 1", b_wr_drop); end
        b_rd_bank = 2'd3;
        tick();
        vectors++;
        if (b_wr_drop !== 1'b0) begin miscompares++; $display("FAIL oor_drop_width: got %b want 0", b_wr_drop); end
        vectors++;
        if (b_rd_data !== '0) begin miscompares++; $display("FAIL oor_rd: got %h want 0", b_rd_data); end
        b_rd_bank = 2'd2;
        tick();
        vectors++;
        if (b_rd_data !== p30) begin miscompares++; $display("FAIL oor_bank2_intact: got %h want %h", b_rd_data, p30); end
        b_rd_bank = 2'd0;
        tick();
        vectors++;
        if (b_rd_data !== '0) begin miscompares++; $display("FAIL oor_bank0_intact: got %h want 0", b_rd_data); end
        b_copy_req = 1'b1; b_copy_src = 2'd2; b_copy_dst = 2'd3;
        tick();
        b_copy_req = 1'b0;
        vectors++;
        if (b_busy !== 1'b0) begin miscompares++; $display("FAIL oor_copy_dst: got %b want 0", b_busy); end
        tick();
        vectors++;
        if (b_copy_done !== 1'b0) begin miscompares++; $display("FAIL oor_copy_no_done: got %b want 0", b_copy_done); end
        b_copy_req = 1'b1; b_copy_src = 2'd2; b_copy_dst = 2'd1;
        tick();
        b_copy_req = 1'b0;
        repeat (4) tick();
        vectors++;
        if (b_copy_done !== 1'b1) begin miscompares++; $display("FAIL b3_copy_done: got %b want 1", b_copy_done); end
        b_rd_bank = 2'd1;
        tick();
        vectors++;
        if (b_rd_data !== p30) begin miscompares++; $display("FAIL b3_copy_dst: got %h want %h", b_rd_data, p30); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a_wr_en = 1'b0; a_wr_bank = 1'b0; a_wr_data = '0; a_rd_bank = 1'b0;
        a_copy_req = 1'b0; a_copy_src = 1'b0; a_copy_dst = 1'b0;
        b_wr_en = 1'b0; b_wr_bank = '0; b_wr_data = '0; b_rd_bank = '0;
        b_copy_req = 1'b0; b_copy_src = '0; b_copy_dst = '0;

        test_reset();
        test_bulk_write();
        test_read_before_write();
        test_copy();
        test_conflict();
        test_reset_mid_copy();
        test_out_of_range();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
